// File: rtl/piso_reg.sv
// piso_reg: parallel-in/serial-out register with valid/ready load and serial stream handshakes.
// Define PISO_MSB_FIRST_EN to emit words MSB first instead of LSB first.
module piso_reg #(
    parameter int DATAWIDTH = 32,
    localparam int CNT_W = $clog2(DATAWIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] d,
    input  logic                 load_valid,
    output logic                 load_ready,
    output logic                 sout,
    output logic                 sout_valid,
    input  logic                 sout_ready,
    output logic                 sout_last
);
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATAWIDTH - 1);
    state_t state, state_nx;
    logic [DATAWIDTH-1:0] sr, sr_nx, sr_sh;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic load, beat;
`ifdef PISO_MSB_FIRST_EN
    assign sr_sh = {sr[DATAWIDTH-2:0], 1'b0};
    assign sout  = sout_valid & sr[DATAWIDTH-1];
`else
    assign sr_sh = {1'b0, sr[DATAWIDTH-1:1]};
    assign sout  = sout_valid & sr[0];
`endif
    assign sout_valid = state == SHIFT;
    assign sout_last  = sout_valid && cnt == LAST;
    // ready is forced low while in reset so requests during reset are ignored
    assign load_ready = rst && (state == IDLE || (sout_last && sout_ready));
    assign load       = load_valid && load_ready;
    assign beat       = sout_valid && sout_ready;
    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        cnt_nx   = cnt;
        if (load) begin
            state_nx = SHIFT;
            sr_nx    = d;
            cnt_nx   = '0;
        end else if (beat) begin
            state_nx = sout_last ? IDLE : SHIFT;
            sr_nx    = sout_last ? '0 : sr_sh;
            cnt_nx   = sout_last ? '0 : cnt + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            sr    <= sr_nx;
            cnt   <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_piso_reg.sv
// tb_piso_reg: scoreboard bench for piso_reg with DATAWIDTH=8 (follows PISO_MSB_FIRST_EN if defined).
module tb_piso_reg;
    logic       clk = 0;
    logic       rst = 0;
    logic [7:0] d = '0;
    logic       load_valid = 0;
    logic       load_ready;
    logic       sout;
    logic       sout_valid;
    logic       sout_ready = 0;
    logic       sout_last;
    logic [1:0] sb[$];
    logic [1:0] exp_beat;
    int ncmp = 0;
    int nerr = 0;

    piso_reg #(.DATAWIDTH(8)) dut (
        .clk(clk), .rst(rst), .d(d), .load_valid(load_valid), .load_ready(load_ready),
        .sout(sout), .sout_valid(sout_valid), .sout_ready(sout_ready), .sout_last(sout_last)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // expected {last, bit} pairs in emission order
    task automatic push_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
`ifdef PISO_MSB_FIRST_EN
            sb.push_back({i == 7, w[7-i]});
`else
            sb.push_back({i == 7, w[i]});
`endif
        end
    endtask

    task automatic test_reset();
        rst = 0; load_valid = 1; d = 8'hFF; sout_ready = 1;
        step();
        ncmp++;
        if ({load_ready, sout_valid, sout, sout_last} !== 4'b0000) begin
            nerr++; $display("FAIL reset_outputs got=%b exp=0000", {load_ready, sout_valid, sout, sout_last});
        end
        load_valid = 0;
        step();
        rst = 1;
        #1;
        ncmp++;
        if ({load_ready, sout_valid} !== 2'b10) begin
            nerr++; $display("FAIL reset_release got=%b exp=10", {load_ready, sout_valid});
        end
    endtask

    task automatic test_basic(input logic [7:0] w);
        sout_ready = 1; d = w; load_valid = 1;
        #1;
        ncmp++;
        if (load_ready !== 1'b1) begin nerr++; $display("FAIL basic_idle_ready got=%b exp=1", load_ready); end
        push_word(w);
        step();
        load_valid = 0; d = ~w;
        #1;
        for (int i = 0; i < 8; i++) begin
            ncmp++;
            if (sout_valid !== 1'b1) begin
                nerr++; $display("FAIL basic_valid beat=%0d got=%b exp=1", i, sout_valid);
            end else begin
                exp_beat = sb.pop_front();
                if ({sout_last, sout} !== exp_beat) begin
                    nerr++; $display("FAIL basic_beat w=%h beat=%0d got=%b exp=%b", w, i, {sout_last, sout}, exp_beat);
                end
            end
            step();
        end
        ncmp++;
        if (sout_valid !== 1'b0) begin nerr++; $display("FAIL basic_idle_after got=%b exp=0", sout_valid); end
    endtask

    task automatic test_stall();
        sout_ready = 1; d = 8'h0F; load_valid = 1;
        push_word(8'h0F);
        step();
        load_valid = 0;
        for (int c = 0; c < 11; c++) begin
            sout_ready = (c >= 2 && c < 5) ? 1'b0 : 1'b1;
            #1;
            ncmp++;
            if (!sout_ready) begin
                if ({sout_valid, sout_last, sout} !== {1'b1, sb[0]}) begin
                    nerr++; $display("FAIL stall_hold cyc=%0d got=%b exp=%b", c, {sout_valid, sout_last, sout}, {1'b1, sb[0]});
                end
            end else if (sout_valid !== 1'b1 || sb.size() == 0) begin
                nerr++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", c, sout_valid);
            end else begin
                exp_beat = sb.pop_front();
                if ({sout_last, sout} !== exp_beat) begin
                    nerr++; $display("FAIL stall_beat cyc=%0d got=%b exp=%b", c, {sout_last, sout}, exp_beat);
                end
            end
            step();
        end
        ncmp++;
        if (sout_valid !== 1'b0 || sb.size() != 0) begin
            nerr++; $display("FAIL stall_end valid=%b left=%0d exp valid=0 left=0", sout_valid, sb.size());
        end
    endtask

    // second word offered from the start of the first; accepted only on the first word's last beat
    task automatic test_back_to_back(input logic [7:0] w0, input logic [7:0] w1, input int hold_from);
        sout_ready = 1; d = w0; load_valid = 1;
        push_word(w0);
        step();
        load_valid = 0; d = w1;
        for (int i = 0; i < 16; i++) begin
            load_valid = (i >= hold_from && i <= 7);
            #1;
            if (i >= hold_from && i <= 7) begin
                ncmp++;
                if (load_ready !== (i == 7)) begin
                    nerr++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", i, load_ready, i == 7);
                end
                if (i == 7) push_word(w1);
            end
            ncmp++;
            if (sout_valid !== 1'b1 || sb.size() == 0) begin
                nerr++; $display("FAIL b2b_valid cyc=%0d got=%b exp=1", i, sout_valid);
            end else begin
                exp_beat = sb.pop_front();
                if ({sout_last, sout} !== exp_beat) begin
                    nerr++; $display("FAIL b2b_beat cyc=%0d got=%b exp=%b", i, {sout_last, sout}, exp_beat);
                end
            end
            step();
        end
        load_valid = 0;
        #1;
        ncmp++;
        if (sout_valid !== 1'b0) begin nerr++; $display("FAIL b2b_idle_after got=%b exp=0", sout_valid); end
    endtask

    task automatic test_async_reset();
        sout_ready = 1; d = 8'h18; load_valid = 1;
        push_word(8'h18);
        step();
        load_valid = 0;
        for (int i = 0; i < 4; i++) begin
            exp_beat = sb.pop_front();
            ncmp++;
            if ({sout_valid, sout_last, sout} !== {1'b1, exp_beat}) begin
                nerr++; $display("FAIL arst_pre beat=%0d got=%b exp=%b", i, {sout_valid, sout_last, sout}, {1'b1, exp_beat});
            end
            step();
        end
        ncmp++;
        if ({sout_valid, sout} !== 2'b11) begin nerr++; $display("FAIL arst_bit5 got=%b exp=11", {sout_valid, sout}); end
        #2 rst = 0;
        #1;
        ncmp++;
        if ({load_ready, sout_valid, sout, sout_last} !== 4'b0000) begin
            nerr++; $display("FAIL arst_immediate got=%b exp=0000", {load_ready, sout_valid, sout, sout_last});
        end
        sb.delete();
        step();
        step();
        rst = 1;
        #1;
        ncmp++;
        if ({load_ready, sout_valid} !== 2'b10) begin
            nerr++; $display("FAIL arst_release got=%b exp=10", {load_ready, sout_valid});
        end
        test_basic(8'h5A);
    endtask

    initial begin
        test_reset();
        test_basic(8'hA5);
        test_basic(8'h01);
        test_stall();
        test_back_to_back(8'hFF, 8'h00, 0);
        test_back_to_back(8'h81, 8'h3C, 3);
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/piso_reg.md
Name: piso_reg

Overview:
- Parallel-in/serial-out register for the datapath component library.
- Accepts one DATAWIDTH-bit word over a valid/ready load handshake and emits it one bit per accepted beat on a serial valid/ready stream, with a last marker on the final bit.
- It is the transmit end of a serial link whose receive end is a plain capture register.
- It sits between a wide datapath register and any narrow serial consumer.

Parameters:
- DATAWIDTH, 32, width of the parallel word; legal range is 2 or more.
- CNT_W, $clog2(DATAWIDTH), width of the bit counter; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-low; 0 = reset.
- d  input  DATAWIDTH  parallel word to send.
- load_valid  input  1  d is valid.
- load_ready  output  1  block accepts d this cycle.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout is valid.
- sout_ready  input  1  consumer accepts sout this cycle.
- sout_last  output  1  sout is the final bit of the word.

Behaviour:
- Reset:
  - rst low asynchronously forces state=IDLE, shift register=0, counter=0.
  - While rst is low: sout=0, sout_valid=0, sout_last=0, load_ready=0.
  - Load requests made during reset are ignored.
- Reset mid-word: the word in flight is discarded with no further bits. After release the block is in IDLE with load_ready=1.
- States: IDLE, SHIFT.
- IDLE:
  - load_ready=1, sout_valid=0, sout=0, sout_last=0.
  - Load fires when load_valid and load_ready are both 1 at a rising edge.
  - On a load: shift register<=d, counter<=0, state<=SHIFT.
- SHIFT:
  - sout_valid=1.
  - sout = shift register bit 0 (LSB-first by default).
  - sout_last = (counter == DATAWIDTH-1).
- Beat: sout_valid and sout_ready both 1 at a rising edge.
  - Non-last beat: shift register shifts right by one, zero fills the MSB, counter increments.
  - sout_ready=0 holds sout, sout_last and counter stable.
- Last beat, no load in the same cycle: state<=IDLE, shift register<=0, counter<=0.
- Back-to-back words:
  - In SHIFT, load_ready = sout_last AND sout_ready (combinational).
  - If load_valid is also 1 on the last beat, the new d loads, counter<=0, and the state stays SHIFT.
  - This gives zero bubble between words.
  - In SHIFT with no last beat, load_ready=0 and d is ignored.
- Latency: the first bit of a word appears on sout the cycle after the load edge. With sout_ready held at 1, a word takes exactly DATAWIDTH cycles.
- Counter: CNT_W bits. It never exceeds DATAWIDTH-1 and never wraps mid-word.
- d is sampled only on the load edge; later changes to d do not affect the word in flight.
- Combinational paths:
  - sout, sout_valid and sout_last depend on registered state only.
  - load_ready depends combinationally on sout_ready.

Optional Feature:
- Macro: PISO_MSB_FIRST_EN.
- Defined:
  - sout = shift register bit DATAWIDTH-1.
  - Each beat shifts left with zero fill at the LSB.
  - The word is emitted MSB first.
- Undefined: LSB-first as described under Behaviour.
- Handshake, counter, sout_last and timing are identical in both builds.

Test Plan:
- Basic word (DATAWIDTH=8): rst released, load d=8'hA5 with sout_ready=1.
  - Required: sout=1,0,1,0,0,1,0,1 on 8 consecutive cycles.
  - sout_last=1 only on the 8th; sout_valid=0 on the 9th.
- Stall (DATAWIDTH=8): load 8'h0F, hold sout_ready=0 for 3 cycles after the 2nd bit.
  - Required: sout holds 1 and the counter is frozen during the stall.
  - The sequence completes as 1,1,1,1,0,0,0,0 with sout_last on the 8th accepted beat.
- Back-to-back (DATAWIDTH=8): keep load_valid=1 with 8'hFF then 8'h00.
  - Required: load_ready=1 on the last beat of 8'hFF.
  - 16 consecutive valid bits (eight 1s then eight 0s), sout_last on cycles 8 and 16.
- Load ignored mid-word: assert load_valid with d=8'h3C during bit 4 of 8'h81.
  - Required: load_ready=0 and the output stays 1,0,0,0,0,0,0,1.
  - 8'h3C is taken only at the last beat.
- Async reset mid-word: drive rst low between edges during bit 5.
  - Required: sout_valid, sout and sout_last go to 0 immediately, before the next edge.
  - After release, load_ready=1 and a fresh 8'h5A serialises correctly.
- MSB-first build with PISO_MSB_FIRST_EN defined (DATAWIDTH=8): load 8'hA5 with sout_ready=1.
  - Required: sout=1,0,1,0,0,1,0,1 (palindrome check).
  - Load 8'h01: sout=0,0,0,0,0,0,0,1 with sout_last on the final 1.
